// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Conditions raw, asynchronous DIP-switch pins for the LED and
//             display logic. Every bit goes through a two-flop synchronizer
//             and then its own debounce state machine with a private counter.
//             The block produces clean levels and one-cycle rise/fall strobes.
//
//  Ports    : clk      in   1      system clock (HSOSC-derived 48 MHz)
//             reset_n  in   1      asynchronous active-low reset
//             s_raw    in   WIDTH  raw switch pins, asynchronous to clk
//             s_clean  out  WIDTH  debounced switch levels
//             s_rise   out  WIDTH  one-cycle pulse when s_clean goes 0->1
//             s_fall   out  WIDTH  one-cycle pulse when s_clean goes 1->0
//             changed  out  1      one-cycle pulse, OR of all rise|fall bits
//
//  Params   : WIDTH            number of switch bits
//             DEBOUNCE_CYCLES  cycles sync2 must differ from s_clean before
//                              the new level is accepted (>= 2)
//             CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
//  Revision : 1.0  initial release
// ============================================================================
module switch_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int CNT_W           = 18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] s_raw,
   output logic [WIDTH-1:0] s_clean,
   output logic [WIDTH-1:0] s_rise,
   output logic [WIDTH-1:0] s_fall,
   output logic             changed
);

   // Terminal count: a commit happens on the edge after cnt reaches it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer. Only sync2 is used by the debounce logic.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = s_raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // Next-cycle strobe values of every bit, gathered for the changed OR.
   logic [WIDTH-1:0] rise_d_vec;
   logic [WIDTH-1:0] fall_d_vec;

   // -------------------------------------------------------------------------
   // Per-bit debounce state machines, fully independent of each other.
   // -------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         state_t           state_q, state_d;
         logic [CNT_W-1:0] cnt_q,   cnt_d;
         logic             clean_q, clean_d;
         logic             rise_q,  rise_d;
         logic             fall_q,  fall_d;

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;

            case (state_q)
               ST_STABLE: begin
                  // Counter is parked at zero while the level agrees.
                  cnt_d = '0;
                  if (sync2_q[i] != clean_q) begin
                     state_d = ST_SETTLING;
                  end
               end

               ST_SETTLING: begin
                  if (sync2_q[i] == clean_q) begin
                     // Bounce reverted before the window elapsed.
                     state_d = ST_STABLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     // Held long enough: accept the new level. The strobe
                     // is registered alongside s_clean so both show in the
                     // same cycle.
                     clean_d = sync2_q[i];
                     rise_d  = sync2_q[i];
                     fall_d  = ~sync2_q[i];
                     state_d = ST_STABLE;
                     cnt_d   = '0;
                  end else begin
                     // Cannot pass CNT_LAST, so the counter never wraps.
                     cnt_d = cnt_q + 1'b1;
                  end
               end

               default: begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               state_q <= ST_STABLE;
               cnt_q   <= '0;
               clean_q <= 1'b0;
               rise_q  <= 1'b0;
               fall_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               clean_q <= clean_d;
               rise_q  <= rise_d;
               fall_q  <= fall_d;
            end
         end

         assign s_clean[i]    = clean_q;
         assign s_rise[i]     = rise_q;
         assign s_fall[i]     = fall_q;
         assign rise_d_vec[i] = rise_d;
         assign fall_d_vec[i] = fall_d;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Aggregate change strobe: one pulse even when several bits commit on
   // the same edge.
   // -------------------------------------------------------------------------
   logic changed_q, changed_d;

   always_comb begin
      changed_d = |(rise_d_vec | fall_d_vec);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debounce
//  Purpose  : Self-checking bench for switch_debounce with DEBOUNCE_CYCLES=8.
//             A window model predicts outputs every cycle; directed literal
//             expectations pin the model at the interesting edges.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_debounce;

   localparam int WIDTH = 4;
   localparam int DC    = 8;
   localparam int CW    = 4;
   localparam int HL    = DC + 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] s_raw;
   logic [WIDTH-1:0] s_clean;
   logic [WIDTH-1:0] s_rise;
   logic [WIDTH-1:0] s_fall;
   logic             changed;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   switch_debounce #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DC),
      .CNT_W          (CW)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .s_raw  (s_raw),
      .s_clean(s_clean),
      .s_rise (s_rise),
      .s_fall (s_fall),
      .changed(changed)
   );

   // ------------------------------------------------------------------------
   // Model: keep the raw level sampled on each edge. The FSM at edge n reacts
   // to the sample taken at edge n-2, so a bit commits at edge n exactly when
   // the DC+1 samples from edges n-DC-2 .. n-2 all disagree with the current
   // clean level. Before the update hist[k] is the sample from edge n-1-k.
   // ------------------------------------------------------------------------
   logic [HL-1:0][WIDTH-1:0] hist;
   logic [WIDTH-1:0]         m_clean, m_rise, m_fall, w_commit;
   logic                     m_changed;

   always_comb begin
      w_commit = '1;
      for (int k = 1; k <= DC + 1; k++) begin
         w_commit = w_commit & (hist[k] ^ m_clean);
      end
   end

   assign m_changed = |(m_rise | m_fall);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         m_clean <= '0;
         m_rise  <= '0;
         m_fall  <= '0;
      end else begin
         hist    <= {hist[HL-2:0], s_raw};
         m_clean <= m_clean ^ w_commit;
         m_rise  <= w_commit & ~m_clean;
         m_fall  <= w_commit & m_clean;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n = 1'b1;
      s_raw   = '0;

      fork
         forever begin
            @(negedge clk);
            checks++;
            if ({s_clean, s_rise, s_fall, changed} !==
                {m_clean, m_rise, m_fall, m_changed}) begin
               errors++;
               $display("FAIL model t=%0t actual clean=%b rise=%b fall=%b chg=%b required clean=%b rise=%b fall=%b chg=%b",
                        $time, s_clean, s_rise, s_fall, changed,
                        m_clean, m_rise, m_fall, m_changed);
            end
         end
      join_none

      #2 reset_n = 1'b0;
      step(3);
      chk("reset_clean",   s_clean, 4'b0000);
      chk("reset_changed", {3'b0, changed}, 4'b0000);
      reset_n = 1'b1;

      // Clean rise on bit 0: commit at edge 11.
      s_raw = 4'b0001;
      step(10);
      chk("rise_e10_clean", s_clean, 4'b0000);
      step(1);
      chk("rise_e11_clean",   s_clean, 4'b0001);
      chk("rise_e11_rise",    s_rise,  4'b0001);
      chk("rise_e11_fall",    s_fall,  4'b0000);
      chk("rise_e11_changed", {3'b0, changed}, 4'b0001);
      step(1);
      chk("rise_e12_rise",    s_rise,  4'b0000);
      chk("rise_e12_changed", {3'b0, changed}, 4'b0000);

      // Short bounce on bit 1: never accepted.
      s_raw = 4'b0011;
      step(3);
      s_raw = 4'b0001;
      step(15);
      chk("bounce_clean", s_clean, 4'b0001);

      // Glitch restart on bit 2.
      s_raw = 4'b0101;
      step(6);
      s_raw = 4'b0001;
      step(1);
      s_raw = 4'b0101;
      step(10);
      chk("glitch_e10_clean", s_clean, 4'b0001);
      step(1);
      chk("glitch_e11_clean", s_clean, 4'b0101);
      chk("glitch_e11_rise",  s_rise,  4'b0100);

      // Reach s_clean=1000 (three bits commit together).
      s_raw = 4'b1000;
      step(11);
      chk("setup_clean", s_clean, 4'b1000);
      chk("setup_rise",  s_rise,  4'b1000);
      chk("setup_fall",  s_fall,  4'b0101);

      // Simultaneous rise on bit 2 and fall on bit 3.
      s_raw = 4'b0100;
      step(10);
      chk("simul_e10_clean", s_clean, 4'b1000);
      step(1);
      chk("simul_clean",   s_clean, 4'b0100);
      chk("simul_rise",    s_rise,  4'b0100);
      chk("simul_fall",    s_fall,  4'b1000);
      chk("simul_changed", {3'b0, changed}, 4'b0001);
      step(1);
      chk("simul_changed_next", {3'b0, changed}, 4'b0000);
      chk("simul_fall_next",    s_fall, 4'b0000);

      // Asynchronous reset between edges.
      s_raw = 4'b0000;
      step(3);
      chk("prereset_clean", s_clean, 4'b0100);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_clean",   s_clean, 4'b0000);
      chk("async_reset_rise",    s_rise,  4'b0000);
      chk("async_reset_fall",    s_fall,  4'b0000);
      chk("async_reset_changed", {3'b0, changed}, 4'b0000);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset in the middle of settling, switch held high through release.
      s_raw = 4'b0001;
      step(6);
      chk("midsettle_clean", s_clean, 4'b0000);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      step(1);
      step(9);
      chk("relrise_e9_clean", s_clean, 4'b0000);
      step(1);
      chk("relrise_clean", s_clean, 4'b0001);
      chk("relrise_rise",  s_rise,  4'b0001);

      // Fall back to zero right after the commit.
      s_raw = 4'b0000;
      step(10);
      chk("fall_e10_clean", s_clean, 4'b0001);
      step(1);
      chk("fall_clean", s_clean, 4'b0000);
      chk("fall_fall",  s_fall,  4'b0001);

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
